// File: rtl/apb_master_bridge_if.sv
// Request/response handshake and APB bus bundle for apb_master_bridge.
// The master modport is the bridge side and the slave modport is the environment side.
`timescale 1ns/1ps
interface apb_master_bridge_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NO_OF_SLAVES  = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_slverr;
    logic                     rsp_timeout;

    logic [NO_OF_SLAVES-1:0]  PSELx;
    logic                     PENABLE;
    logic [ADDRESS_WIDTH-1:0] PADDR;
    logic                     PWRITE;
    logic [DATA_WIDTH-1:0]    PWDATA;
    logic [DATA_WIDTH-1:0]    PRDATA [NO_OF_SLAVES];
    logic [NO_OF_SLAVES-1:0]  PREADY;
    logic [NO_OF_SLAVES-1:0]  PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output PSELx, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  PSELx, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-request APB master: decodes the request address to one slave select,
// runs SETUP/ACCESS with a wait-state timeout and returns one response per request.
`timescale 1ns/1ps
module apb_master_bridge #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NO_OF_SLAVES  = 4,
    parameter int BASE_SHIFT    = 12,
    parameter int TIMEOUT       = 16
) (
    input  logic              clock,
    input  logic              reset,
    apb_master_bridge_if.master bus
);
    localparam int IDX_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         sel_idx;
    logic [CNT_W-1:0]         wait_cnt;
    logic [CNT_W-1:0]         wait_nxt;
    logic [ADDRESS_WIDTH-1:0] req_idx;
    logic                     lane_ready;
    logic                     lane_err;
    logic [DATA_WIDTH-1:0]    lane_rdata;

    assign req_idx    = bus.req_addr >> BASE_SHIFT;
    assign wait_nxt   = wait_cnt + CNT_W'(1);
    // Only the addressed lane is looked at; the others may carry anything.
    assign lane_ready = bus.PREADY[sel_idx];
    assign lane_err   = bus.PSLVERR[sel_idx];
    assign lane_rdata = bus.PRDATA[sel_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            sel_idx         <= '0;
            wait_cnt        <= '0;
            bus.req_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_slverr  <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.PSELx       <= '0;
            bus.PENABLE     <= 1'b0;
            bus.PADDR       <= '0;
            bus.PWRITE      <= 1'b0;
            bus.PWDATA      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        if (req_idx >= ADDRESS_WIDTH'(NO_OF_SLAVES)) begin
                            // Unmapped region: answer with an error, never touch the bus.
                            bus.rsp_valid   <= 1'b1;
                            bus.rsp_rdata   <= '0;
                            bus.rsp_slverr  <= 1'b1;
                            bus.rsp_timeout <= 1'b0;
                            state           <= RESP;
                        end else begin
                            bus.PADDR   <= bus.req_addr;
                            bus.PWRITE  <= bus.req_write;
                            bus.PWDATA  <= bus.req_wdata;
                            bus.PSELx   <= NO_OF_SLAVES'(1) << req_idx[IDX_W-1:0];
                            bus.PENABLE <= 1'b0;
                            sel_idx     <= req_idx[IDX_W-1:0];
                            wait_cnt    <= '0;
                            state       <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (lane_ready) begin
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_rdata   <= bus.PWRITE ? '0 : lane_rdata;
                        bus.rsp_slverr  <= lane_err;
                        bus.rsp_timeout <= 1'b0;
                        bus.PSELx       <= '0;
                        bus.PENABLE     <= 1'b0;
                        state           <= RESP;
                    end else begin
                        wait_cnt <= wait_nxt;
                        if (TIMEOUT != 0 && wait_nxt == CNT_W'(TIMEOUT)) begin
                            bus.rsp_valid   <= 1'b1;
                            bus.rsp_rdata   <= '0;
                            bus.rsp_slverr  <= 1'b1;
                            bus.rsp_timeout <= 1'b1;
                            bus.PSELx       <= '0;
                            bus.PENABLE     <= 1'b0;
                            state           <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed and randomized bench for apb_master_bridge with a reference model of
// latency, select activity and response contents derived from the bridge's rules.
`timescale 1ns/1ps
module tb_apb_master_bridge;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 4;
    localparam int BS = 12;
    localparam int TO = 16;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int          wait_cfg [NS];
    logic        err_cfg  [NS];
    logic [31:0] rd_cfg   [NS];
    int          acc_cnt;
    logic [NS-1:0] prev_sel;
    logic [AW-1:0] last_paddr;

    apb_master_bridge_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NO_OF_SLAVES(NS)) bus ();

    apb_master_bridge #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NO_OF_SLAVES(NS),
        .BASE_SHIFT(BS), .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave model: selected lane raises PREADY after wait_cfg ACCESS cycles;
    // unselected lanes drive misleading values that the bridge must ignore.
    always @(posedge clock) begin
        if (bus.PSELx != '0 && bus.PENABLE) acc_cnt <= acc_cnt + 1;
        else                                acc_cnt <= 0;
    end

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            if (bus.PSELx[i]) begin
                bus.PREADY[i]  = bus.PENABLE && (acc_cnt >= wait_cfg[i]);
                bus.PSLVERR[i] = err_cfg[i];
                bus.PRDATA[i]  = rd_cfg[i];
            end else begin
                bus.PREADY[i]  = 1'b1;
                bus.PSLVERR[i] = 1'b1;
                bus.PRDATA[i]  = 32'hBAD0_0000 | 32'(i);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus invariants: at most one select, PENABLE only with a select, never in its first cycle.
    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            assert ($onehot0(bus.PSELx) && (!bus.PENABLE || (bus.PSELx != '0 && prev_sel == bus.PSELx)))
            else begin
                errors++;
                $error("FAIL apb_invariant observed PSELx=0x%0h PENABLE=%0b prev=0x%0h expected legal APB",
                       bus.PSELx, bus.PENABLE, prev_sel);
            end
        end
        prev_sel <= reset ? '0 : bus.PSELx;
    end

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        int unsigned idx;
        int          lat, selc, cyc, sel_cyc;
        logic [31:0] e_rd;
        logic        e_err, e_to, got, dec;
        logic [31:0] rd0;
        logic        err0, to0;

        idx = addr >> BS;
        dec = (idx >= NS);
        if (dec) begin
            lat = 1; selc = 0; e_rd = 0; e_err = 1; e_to = 0;
        end else if (wait_cfg[idx] >= TO) begin
            lat = 2 + TO; selc = 1 + TO; e_rd = 0; e_err = 1; e_to = 1;
        end else begin
            lat = 3 + wait_cfg[idx]; selc = 2 + wait_cfg[idx];
            e_rd = wr ? 32'h0 : rd_cfg[idx]; e_err = err_cfg[idx]; e_to = 0;
        end

        @(negedge clock);
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;

        cyc = 0; sel_cyc = 0; got = 0;
        while (!got && cyc < 64) begin
            @(negedge clock);
            cyc++;
            if (bus.rsp_valid) got = 1;
            else begin
                if (bus.PSELx != '0) sel_cyc++;
                if (cyc == 1) begin
                    check("setup_psel", bus.PSELx, 4'b0001 << idx);
                    check("setup_penable", bus.PENABLE, 0);
                    check("setup_paddr", bus.PADDR, addr);
                    check("setup_pwrite", bus.PWRITE, wr);
                    check("setup_pwdata", bus.PWDATA, wdata);
                    check("busy_req_ready", bus.req_ready, 0);
                end
                if (cyc == 2) begin
                    check("access_penable", bus.PENABLE, 1);
                    check("access_psel", bus.PSELx, 4'b0001 << idx);
                end
            end
        end
        if (!dec) last_paddr = addr;
        check("rsp_latency", got ? cyc : 0, lat);
        check("psel_cycles", sel_cyc, selc);
        check("rsp_psel_clear", {bus.PSELx, bus.PENABLE}, 0);
        check("rsp_rdata", bus.rsp_rdata, e_rd);
        check("rsp_slverr", bus.rsp_slverr, e_err);
        check("rsp_timeout", bus.rsp_timeout, e_to);
        rd0 = bus.rsp_rdata; err0 = bus.rsp_slverr; to0 = bus.rsp_timeout;

        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_fields", {bus.rsp_rdata, bus.rsp_slverr, bus.rsp_timeout}, {rd0, err0, to0});
            check("hold_req_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clock);
        check("post_rsp_valid", bus.rsp_valid, 0);
        check("post_req_ready", bus.req_ready, 1);
        check("post_fields", {bus.rsp_rdata, bus.rsp_slverr, bus.rsp_timeout}, {rd0, err0, to0});
        check("paddr_hold", bus.PADDR, last_paddr);
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
        bus.rsp_ready = 0;
        last_paddr = 0;
        for (int i = 0; i < NS; i++) begin
            wait_cfg[i] = 0; err_cfg[i] = 0; rd_cfg[i] = 32'h1000_0000 + 32'(i);
        end
        repeat (2) @(negedge clock);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_apb_ctl", {bus.PSELx, bus.PENABLE, bus.PWRITE}, 0);
        check("rst_paddr", bus.PADDR, 0);
        check("rst_pwdata", bus.PWDATA, 0);
        reset = 1'b0;

        // Zero-wait write to slave 1.
        run_txn(1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 0);
        // Read with three wait states on slave 3.
        wait_cfg[3] = 3; rd_cfg[3] = 32'h1234_5678;
        run_txn(1'b0, 32'h0000_3004, 32'hCAFE_0001, 0);
        // Decode error.
        run_txn(1'b0, 32'h0000_4000, 32'h0, 0);
        // Stuck slave 2 times out.
        wait_cfg[2] = 1000;
        run_txn(1'b0, 32'h0000_2000, 32'h0, 1);
        // Slave error on slave 0 with a stalled consumer.
        wait_cfg[0] = 0; err_cfg[0] = 1; rd_cfg[0] = 32'hA5A5_0F0F;
        run_txn(1'b0, 32'h0000_0020, 32'h0, 5);

        // Reset in the middle of an ACCESS phase.
        err_cfg[0] = 0; wait_cfg[1] = 10;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_1008;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("pre_rst_penable", bus.PENABLE, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_apb", {bus.PSELx, bus.PENABLE}, 0);
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_req_ready", bus.req_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        last_paddr = 0;
        run_txn(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 0);

        // Randomized traffic.
        for (int n = 0; n < 24; n++) begin
            int unsigned ridx;
            for (int i = 0; i < NS; i++) begin
                wait_cfg[i] = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 3))
                                                          : int'($urandom_range(0, 4));
                err_cfg[i]  = ($urandom_range(0, 3) == 0);
                rd_cfg[i]   = $urandom;
            end
            ridx = $urandom_range(0, 5);
            run_txn(1'($urandom_range(0, 1)), (ridx << BS) | ($urandom_range(0, 4095) & 32'hFFC),
                    $urandom, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
